wb_host_master: RTL and testbench
=================================

Name: wb_host_master

Overview:
- Wishbone classic single-transfer initiator. Issues one read or write per command on the 32-bit Wishbone bus that the user-project slave port responds to.
- Used as the bench/host-side driver for that slave port, and as an on-chip bridge from a simple valid/ready command stream.
- One outstanding transaction at a time. Each response carries read data and an error flag.

Parameters:
- AW, 32, address width of cmd_adr / wbm_adr_o
- DW, 32, data width; byte-select width is DW/8
- TIMEOUT_CYCLES, 255, cycles to wait for ack before abort (used only with the optional feature)

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  AW  byte address
- cmd_dat  in  DW  write data
- cmd_sel  in  DW/8  byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_dat  out  DW  read data (0 for writes)
- rsp_err  out  1  transaction aborted by timeout
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  DW/8  Wishbone byte select
- wbm_adr_o  out  AW  Wishbone address
- wbm_dat_o  out  DW  Wishbone write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  DW  slave read data

Behaviour:
- Clock and reset: single clock wb_clk_i; wb_rst_i is asynchronous, active-high.
- Reset values: all outputs registered and reset to 0, except cmd_ready, which is 1 (decoded from IDLE). State resets to IDLE.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch we/adr/dat/sel and go to BUS.
  - wbm_cyc_o and wbm_stb_o go high in the cycle after acceptance (1-cycle issue latency).
- BUS:
  - cmd_ready=0; cyc/stb/we/sel/adr/dat held stable until ack.
  - On wbm_ack_i=1, go to RESP. In the next cycle cyc/stb drop to 0, rsp_valid=1, and rsp_dat = wbm_dat_i sampled on the ack edge (reads) or 0 (writes). rsp_err=0.
  - Ack in the same cycle stb first rises is legal and completes the transfer (minimum bus occupancy 1 cycle).
- RESP:
  - rsp_valid, rsp_dat and rsp_err are held until rsp_ready.
  - On handshake go to IDLE; rsp_valid=0 next cycle.
  - Back-to-back minimum: a new command is accepted the cycle after the response handshake. Command-to-command spacing is 3 cycles with zero-wait-state slaves.
- wbm_ack_i outside BUS is ignored; no state change, no response.
- wbm_we_o, wbm_adr_o, wbm_sel_o and wbm_dat_o keep their last values when cyc=0. This is legal; the slave must qualify them with stb.
- Reset mid-transaction: cyc/stb drop asynchronously, the pending command and any pending response are discarded, no rsp_valid is produced, and state returns to IDLE.
- No retry, no error input, no pipelined (stall) mode; one outstanding transfer only.

Optional Feature:
- Macro WB_HOST_MASTER_TIMEOUT_EN.
- When defined:
  - An 8..32-bit counter (width = clog2(TIMEOUT_CYCLES+1)) clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES without ack: cyc/stb drop next cycle, go to RESP with rsp_err=1 and rsp_dat=0.
  - Ack in the same cycle as the terminal count wins: normal completion, rsp_err=0.
- When not defined: no counter is built; BUS waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Write: cmd_we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave acks after 2 wait cycles -> cyc/stb high exactly 3 cycles with those values; rsp_valid=1, rsp_err=0, rsp_dat=0 one cycle after ack.
- Read: cmd_we=0, adr=0x3000_0008; slave acks with zero wait, wbm_dat_i=0x1234_5678 -> cyc/stb high 1 cycle; rsp_dat=0x1234_5678 held while rsp_ready=0 for 5 cycles.
- Backpressure and back-to-back: cmd_valid held high with two queued commands, rsp_ready=1 -> second command accepted the cycle after the first response handshake; cmd_ready=0 throughout BUS and RESP.
- Spurious ack: pulse wbm_ack_i in IDLE -> no rsp_valid and no state change; a following read completes normally.
- Reset mid-op: assert wb_rst_i asynchronously while in BUS -> cyc/stb/rsp_valid go to 0 without waiting for a clock edge; after release, a read to 0x0 completes normally.
- Timeout (WB_HOST_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never acks -> cyc low after the 4th BUS cycle, rsp_err=1, rsp_dat=0. Repeat with ack arriving at count 4 -> rsp_err=0.

Source files
------------

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command stream.
// Optional ack timeout is enabled by defining WB_HOST_MASTER_TIMEOUT_EN.
module wb_host_master #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic [DW/8-1:0]   r_sel;
  logic [AW-1:0]     r_adr;
  logic [DW-1:0]     r_dat;
  logic              r_rsp_valid;
  logic [DW-1:0]     r_rsp_dat;
  logic              w_accept;
  logic              w_ack;
  logic              w_rsp_hs;
  logic              w_timeout;

  assign w_accept = (r_state == IDLE) && cmd_valid;
  assign w_ack    = (r_state == BUS) && wbm_ack_i;
  assign w_rsp_hs = (r_state == RESP) && rsp_ready;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);
  // Counter holds the number of ack-less BUS cycles already elapsed, so the
  // abort fires in the TIMEOUT_CYCLES-th bus cycle.
  localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_rsp_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == BUS) && !wbm_ack_i) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  assign w_timeout = (r_state == BUS) && !wbm_ack_i && (r_tmo_cnt == TC_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rsp_err <= 1'b0;
    end else if (w_ack || w_timeout) begin
      r_rsp_err <= w_timeout;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_state_next = BUS;
      BUS:     if (wbm_ack_i || w_timeout) w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Bus-side qualifiers stay latched after the transfer; only cyc/stb return low.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
    end else begin
      if (w_accept) begin
        r_cyc <= 1'b1;
        r_stb <= 1'b1;
        r_we  <= cmd_we;
        r_sel <= cmd_sel;
        r_adr <= cmd_adr;
        r_dat <= cmd_dat;
      end
      if (w_ack || w_timeout) begin
        r_cyc       <= 1'b0;
        r_stb       <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_dat   <= (w_ack && !r_we) ? wbm_dat_i : '0;
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: write, read, back-to-back, spurious ack,
// async reset mid-transfer and (with WB_HOST_MASTER_TIMEOUT_EN) ack timeout.
module tb_wb_host_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i = '0;
  logic        ack_auto = 1'b0;
  logic        ack_man = 1'b0;

  int checks = 0;
  int errors = 0;

  // Zero-wait slave acks combinationally from stb; otherwise ack is hand-driven.
  assign wbm_ack_i = ack_auto ? wbm_stb_o : ack_man;

  always #5 clk = ~clk;

  wb_host_master #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Write with two wait states
    wbm_dat_i = 32'hAAAA_5555;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004;
    cmd_dat = 32'hDEAD_BEEF; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    check("wr_c1_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    check("wr_c1_stb", {31'b0, wbm_stb_o}, 32'd1);
    check("wr_we", {31'b0, wbm_we_o}, 32'd1);
    check("wr_adr", wbm_adr_o, 32'h3000_0004);
    check("wr_dat", wbm_dat_o, 32'hDEAD_BEEF);
    check("wr_sel", {28'b0, wbm_sel_o}, 32'hF);
    check("wr_bus_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    tick();
    check("wr_c2_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    check("wr_c2_adr", wbm_adr_o, 32'h3000_0004);
    tick();
    ack_man = 1'b1;
    check("wr_c3_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    check("wr_c3_dat", wbm_dat_o, 32'hDEAD_BEEF);
    tick();
    ack_man = 1'b0;
    check("wr_resp_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("wr_resp_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("wr_rsp_dat", rsp_dat, 32'd0);
    check("wr_resp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("wr_hold_adr", wbm_adr_o, 32'h3000_0004);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("wr_done_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Zero-wait read, response held under backpressure
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0008; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    ack_man = 1'b1; wbm_dat_i = 32'h1234_5678;
    check("rd_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    check("rd_we", {31'b0, wbm_we_o}, 32'd0);
    check("rd_adr", wbm_adr_o, 32'h3000_0008);
    tick();
    ack_man = 1'b0; wbm_dat_i = 32'hFFFF_FFFF;
    check("rd_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rd_hold%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("rd_hold%0d_dat", i), rsp_dat, 32'h1234_5678);
      check($sformatf("rd_hold%0d_rdy", i), {31'b0, cmd_ready}, 32'd0);
      tick();
    end
    check("rd_hold_valid_end", {31'b0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    check("rd_done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rd_done_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Back-to-back commands with a zero-wait slave and rsp_ready held high
    ack_auto = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0100; cmd_dat = 32'h0000_0011;
    tick();
    check("b2b_c1_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    check("b2b_c1_adr", wbm_adr_o, 32'h3000_0100);
    check("b2b_c1_bus_rdy", {31'b0, cmd_ready}, 32'd0);
    cmd_we = 1'b0; cmd_adr = 32'h3000_0200;
    tick();
    check("b2b_c1_resp_rdy", {31'b0, cmd_ready}, 32'd0);
    check("b2b_c1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b_c1_rsp_dat", rsp_dat, 32'd0);
    check("b2b_c1_resp_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    tick();
    check("b2b_idle_rdy", {31'b0, cmd_ready}, 32'd1);
    check("b2b_idle_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("b2b_idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("b2b_c2_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    check("b2b_c2_adr", wbm_adr_o, 32'h3000_0200);
    check("b2b_c2_we", {31'b0, wbm_we_o}, 32'd0);
    tick();
    check("b2b_c2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b_c2_rsp_dat", rsp_dat, 32'hCAFE_F00D);
    tick();
    check("b2b_c2_done", {31'b0, rsp_valid}, 32'd0);

    // Spurious ack in IDLE is ignored
    ack_auto = 1'b0; ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("spur_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("spur_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("spur_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    tick();
    check("spur_rsp_valid2", {31'b0, rsp_valid}, 32'd0);
    ack_auto = 1'b1; wbm_dat_i = 32'h0BAD_F00D;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0010;
    tick();
    cmd_valid = 1'b0;
    check("spur_rd_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    tick();
    check("spur_rd_valid", {31'b0, rsp_valid}, 32'd1);
    check("spur_rd_dat", rsp_dat, 32'h0BAD_F00D);
    tick();
    check("spur_rd_done", {31'b0, rsp_valid}, 32'd0);

    // Asynchronous reset while waiting in BUS
    ack_auto = 1'b0; ack_man = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040;
    tick();
    cmd_valid = 1'b0;
    check("rstop_cyc_before", {31'b0, wbm_cyc_o}, 32'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("rstop_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("rstop_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("rstop_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rstop_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rstop_adr", wbm_adr_o, 32'd0);
    #2 rst = 1'b0;
    tick();
    check("rstop_post_valid", {31'b0, rsp_valid}, 32'd0);
    ack_auto = 1'b1; wbm_dat_i = 32'h5A5A_5A5A;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0;
    tick();
    cmd_valid = 1'b0;
    check("rstop_rd_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    check("rstop_rd_adr", wbm_adr_o, 32'h0);
    tick();
    check("rstop_rd_valid", {31'b0, rsp_valid}, 32'd1);
    check("rstop_rd_dat", rsp_dat, 32'h5A5A_5A5A);
    tick();
    check("rstop_rd_done", {31'b0, rsp_valid}, 32'd0);

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    // Timeout after 4 ack-less bus cycles
    ack_auto = 1'b0; ack_man = 1'b0; wbm_dat_i = 32'h7777_7777;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0080;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tmo_cyc%0d", i), {31'b0, wbm_cyc_o}, 32'd1);
      tick();
    end
    check("tmo_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
    check("tmo_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("tmo_rsp_err", {31'b0, rsp_err}, 32'd1);
    check("tmo_rsp_dat", rsp_dat, 32'd0);
    tick();
    check("tmo_done", {31'b0, rsp_valid}, 32'd0);

    // Ack in the terminal-count cycle completes normally
    cmd_valid = 1'b1; cmd_adr = 32'h3000_0084;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tmoack_cyc%0d", i), {31'b0, wbm_cyc_o}, 32'd1);
      if (i == 3) ack_man = 1'b1;
      tick();
    end
    ack_man = 1'b0;
    check("tmoack_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("tmoack_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("tmoack_rsp_dat", rsp_dat, 32'h7777_7777);
    tick();
    check("tmoack_done", {31'b0, rsp_valid}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
